// File: rtl/level_delay_timer.sv
// -----------------------------------------------------------------------------
// level_delay_timer
//
// Programmable delay timer counting in coarse "ticks" of TICK_DIV clk cycles.
// A request loads a delay of N ticks; when it runs out, slowClk pulses high
// for exactly one cycle. The delay can be paused, cancelled, or retriggered
// by a new request at any time.
//
// Parameters:
//   TICK_DIV        clk cycles per tick (legal 2 .. 2**24)
//
// Ports:
//   clk             system clock, rising edge
//   resetN          asynchronous active-low reset
//   requestTime     load request (level-sensitive, reloads on every high cycle)
//   slowClkRequest  requested delay in ticks, captured while requestTime=1
//   pauseTimer      freezes the count while high
//   cancel          aborts the delay with no expiry pulse
//   slowClk         one-cycle expiry pulse (state DONE)
//   busy            delay loaded and not yet expired (state RUN or PAUSED)
//   remaining       ticks left
//   timerState      debug view of the FSM: 0=IDLE 1=RUN 2=PAUSED 3=DONE
//
// Input priority at every edge: cancel > requestTime > pauseTimer > counting.
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module level_delay_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        requestTime,
    input  logic [10:0] slowClkRequest,
    input  logic        pauseTimer,
    input  logic        cancel,
    output logic        slowClk,
    output logic        busy,
    output logic [10:0] remaining,
    output logic [1:0]  timerState
);

    // Prescaler must hold TICK_DIV-1; for TICK_DIV=2 that is a single bit.
    localparam int              PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_prescaler;
    logic [PW-1:0] w_prescaler_nxt;
    logic [10:0]   r_remaining;
    logic [10:0]   w_remaining_nxt;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_prescaler <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prescaler <= w_prescaler_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Defaults: return to an idle, cleared timer.
        w_state_nxt     = ST_IDLE;
        w_prescaler_nxt = '0;
        w_remaining_nxt = '0;

        if (cancel) begin
            // Abort everything; defaults already describe IDLE with zeros.
            w_state_nxt = ST_IDLE;
        end else if (requestTime) begin
            // A request wins in every state, so RUN/PAUSED get a retrigger
            // and DONE still shows its pulse this cycle (it is registered).
            if (slowClkRequest == 11'd0) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_remaining_nxt = slowClkRequest;
                w_state_nxt     = pauseTimer ? ST_PAUSED : ST_RUN;
            end
        end else begin
            unique case (r_state)
                ST_RUN, ST_PAUSED: begin
                    if (pauseTimer) begin
                        w_state_nxt     = ST_PAUSED;
                        w_prescaler_nxt = r_prescaler;
                        w_remaining_nxt = r_remaining;
                    end else if (r_prescaler == PRE_MAX) begin
                        // Tick boundary. The edge that leaves PAUSED counts
                        // like any RUN edge, so only paused edges are added.
                        w_prescaler_nxt = '0;
                        if (r_remaining <= 11'd1) begin
                            // Guarded with <= so remaining can never wrap.
                            w_state_nxt     = ST_DONE;
                            w_remaining_nxt = '0;
                        end else begin
                            w_state_nxt     = ST_RUN;
                            w_remaining_nxt = r_remaining - 11'd1;
                        end
                    end else begin
                        w_state_nxt     = ST_RUN;
                        w_prescaler_nxt = r_prescaler + 1'b1;
                        w_remaining_nxt = r_remaining;
                    end
                end
                ST_DONE: begin
                    // Pulse lasts one cycle.
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    // IDLE: pauseTimer is ignored, counters stay cleared.
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state
    // -------------------------------------------------------------------------
    assign slowClk    = (r_state == ST_DONE);
    assign busy       = (r_state == ST_RUN) || (r_state == ST_PAUSED);
    assign remaining  = r_remaining;
    assign timerState = r_state;

endmodule

// File: tb/tb_level_delay_timer.sv
// -----------------------------------------------------------------------------
// tb_level_delay_timer
//
// Two instances: dut_a with TICK_DIV=4 for the functional scenarios and
// dut_b with TICK_DIV=2 for the longest (2047-tick) delay. Expected expiry
// cycles are pushed into a queue when a request is driven; a monitor pops
// them when slowClk pulses and compares the cycle number.
// -----------------------------------------------------------------------------
module tb_level_delay_timer;

    localparam int TD_A = 4;
    localparam int TD_B = 2;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // DUTs
    // -------------------------------------------------------------------------
    logic        req_a = 1'b0, pause_a = 1'b0, cancel_a = 1'b0;
    logic [10:0] n_a = '0;
    logic        slow_a, busy_a;
    logic [10:0] rem_a;
    logic [1:0]  st_a;

    logic        req_b = 1'b0, pause_b = 1'b0, cancel_b = 1'b0;
    logic [10:0] n_b = '0;
    logic        slow_b, busy_b;
    logic [10:0] rem_b;
    logic [1:0]  st_b;

    level_delay_timer #(.TICK_DIV(TD_A)) dut_a (
        .clk            (clk),
        .resetN         (resetN),
        .requestTime    (req_a),
        .slowClkRequest (n_a),
        .pauseTimer     (pause_a),
        .cancel         (cancel_a),
        .slowClk        (slow_a),
        .busy           (busy_a),
        .remaining      (rem_a),
        .timerState     (st_a)
    );

    level_delay_timer #(.TICK_DIV(TD_B)) dut_b (
        .clk            (clk),
        .resetN         (resetN),
        .requestTime    (req_b),
        .slowClkRequest (n_b),
        .pauseTimer     (pause_b),
        .cancel         (cancel_b),
        .slowClk        (slow_b),
        .busy           (busy_b),
        .remaining      (rem_b),
        .timerState     (st_b)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [31:0] exp_a_v, exp_b_v;
    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expiry monitor: every pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (slow_a === 1'b1) begin
            pulses_a++;
            if (exp_a_q.size() > 0) begin
                exp_a_v = exp_a_q.pop_front();
                check_eq("expiry_cycle_a", 32'(cyc), exp_a_v);
            end else begin
                check_eq("spurious_pulse_a", 32'(slow_a), 32'd0);
            end
        end
        if (slow_b === 1'b1) begin
            if (exp_b_q.size() > 0) begin
                exp_b_v = exp_b_q.pop_front();
                check_eq("expiry_cycle_b", 32'(cyc), exp_b_v);
            end else begin
                check_eq("spurious_pulse_b", 32'(slow_b), 32'd0);
            end
        end
    end

    task automatic wait_drain_a(input int budget);
        int b;
        b = budget;
        while (exp_a_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check_eq("drain_a", 32'(exp_a_q.size()), 32'd0);
        exp_a_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain_b(input int budget);
        int b;
        b = budget;
        while (exp_b_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check_eq("drain_b", 32'(exp_b_q.size()), 32'd0);
        exp_b_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Drive a one-cycle request on dut_a and queue its expected expiry.
    task automatic request_a(input logic [10:0] n, input int latency);
        @(negedge clk);
        req_a = 1'b1;
        n_a   = n;
        exp_a_q.push_back(32'(cyc + 1 + latency));
        @(negedge clk);
        req_a = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check_eq({tag, "_state"}, 32'(st_a), 32'd0);
        check_eq({tag, "_rem"},   32'(rem_a), 32'd0);
        check_eq({tag, "_busy"},  32'(busy_a), 32'd0);
        check_eq({tag, "_slow"},  32'(slow_a), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int p0;

    initial begin
        // Reset state, sampled between edges while clk keeps running.
        repeat (3) @(negedge clk);
        #2;
        check_idle_a("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Basic N=3: remaining 3,2,1 changing at E4,E8; pulse after E12.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd3;
        exp_a_q.push_back(32'(cyc + 1 + 3 * TD_A));
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) req_a = 1'b0;
            check_eq("basic_rem", 32'(rem_a), (k < 4) ? 32'd3 : (k < 8) ? 32'd2 : (k < 12) ? 32'd1 : 32'd0);
            check_eq("basic_state", 32'(st_a), (k < 12) ? 32'd1 : (k == 12) ? 32'd3 : 32'd0);
            check_eq("basic_busy", 32'(busy_a), (k < 12) ? 32'd1 : 32'd0);
        end
        wait_drain_a(10);

        // Pause for 5 edges starting at E2 with N=2: expiry 13 cycles out.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd2;
        exp_a_q.push_back(32'(cyc + 1 + 2 * TD_A + 5));
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        pause_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("pause_rem", 32'(rem_a), 32'd2);
            check_eq("pause_state", 32'(st_a), 32'd2);
            check_eq("pause_busy", 32'(busy_a), 32'd1);
        end
        pause_a = 1'b0;
        wait_drain_a(40);

        // Retrigger: N=5, then N=1 at E6; old delay must never fire.
        p0 = pulses_a;
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd5;
        @(negedge clk);
        req_a = 1'b0;
        repeat (5) @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd1;
        exp_a_q.push_back(32'(cyc + 1 + TD_A));
        @(negedge clk);
        req_a = 1'b0;
        check_eq("retrig_rem", 32'(rem_a), 32'd1);
        wait_drain_a(20);
        repeat (30) @(negedge clk);
        check_eq("retrig_pulse_count", 32'(pulses_a), 32'(p0 + 1));

        // Cancel at E7 of an N=3 run.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd3;
        @(negedge clk);
        req_a = 1'b0;
        repeat (6) @(negedge clk);
        cancel_a = 1'b1;
        @(negedge clk);
        cancel_a = 1'b0;
        check_idle_a("cancel");
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check_eq("cancel_quiet", 32'(slow_a), 32'd0);
        end

        // N=0: immediate pulse, busy never high.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd0;
        exp_a_q.push_back(32'(cyc + 1));
        @(negedge clk);
        req_a = 1'b0;
        check_eq("zero_busy0", 32'(busy_a), 32'd0);
        check_eq("zero_state", 32'(st_a), 32'd3);
        check_eq("zero_rem", 32'(rem_a), 32'd0);
        @(negedge clk);
        check_eq("zero_busy1", 32'(busy_a), 32'd0);
        check_eq("zero_idle", 32'(st_a), 32'd0);
        wait_drain_a(5);

        // Request during DONE keeps that pulse and starts a new delay.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd1;
        exp_a_q.push_back(32'(cyc + 1 + TD_A));
        @(negedge clk);
        req_a = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("done_pulse_seen", 32'(slow_a), 32'd1);
        req_a = 1'b1;
        n_a   = 11'd2;
        exp_a_q.push_back(32'(cyc + 1 + 2 * TD_A));
        @(negedge clk);
        req_a = 1'b0;
        check_eq("done_retrig_state", 32'(st_a), 32'd1);
        check_eq("done_retrig_rem", 32'(rem_a), 32'd2);
        wait_drain_a(30);

        // Request held for three cycles reloads each time.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd1;
        exp_a_q.push_back(32'(cyc + 1 + 2 + TD_A));
        repeat (3) begin
            @(negedge clk);
            check_eq("held_rem", 32'(rem_a), 32'd1);
            check_eq("held_state", 32'(st_a), 32'd1);
        end
        req_a = 1'b0;
        wait_drain_a(20);

        // Longest delay on the TICK_DIV=2 instance.
        @(negedge clk);
        req_b = 1'b1;
        n_b   = 11'd2047;
        exp_b_q.push_back(32'(cyc + 1 + 2047 * TD_B));
        @(negedge clk);
        req_b = 1'b0;
        check_eq("long_rem", 32'(rem_b), 32'd2047);
        check_eq("long_busy", 32'(busy_b), 32'd1);
        wait_drain_b(4200);
        check_eq("long_idle", 32'(st_b), 32'd0);

        // Asynchronous reset mid-run, then silence.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd3;
        @(negedge clk);
        req_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check_idle_a("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 32'(slow_a), 32'd0);
        end
        check_idle_a("post_rst");

        // First edge after reset release already takes a request.
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        req_a  = 1'b1;
        n_a    = 11'd1;
        exp_a_q.push_back(32'(cyc + 1 + TD_A));
        @(negedge clk);
        req_a = 1'b0;
        check_eq("rel_req_state", 32'(st_a), 32'd1);
        check_eq("rel_req_rem", 32'(rem_a), 32'd1);
        wait_drain_a(20);

        // Request and cancel together during a run: cancel wins.
        @(negedge clk);
        req_a = 1'b1;
        n_a   = 11'd3;
        @(negedge clk);
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        req_a    = 1'b1;
        n_a      = 11'd4;
        cancel_a = 1'b1;
        @(negedge clk);
        req_a    = 1'b0;
        cancel_a = 1'b0;
        check_idle_a("req_cancel");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq("req_cancel_quiet", 32'(slow_a), 32'd0);
        end

        check_eq("final_queue_a", 32'(exp_a_q.size()), 32'd0);
        check_eq("final_queue_b", 32'(exp_b_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/level_delay_timer.md
LEVEL_DELAY_TIMER -- requirements
Module: level_delay_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 500000, meaning the number of clk cycles per timer tick (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port requestTime  input  1  load request, sampled every rising edge; level-sensitive, nominally a one-cycle pulse.
REQ-005 The block SHALL have port slowClkRequest  input  11  requested delay in ticks, unsigned, captured only when requestTime=1.
REQ-006 The block SHALL have port pauseTimer  input  1  freezes counting while high.
REQ-007 The block SHALL have port cancel  input  1  aborts the running delay without producing an expiry pulse.
REQ-008 The block SHALL have port slowClk  output  1  registered one-cycle expiry pulse.
REQ-009 The block SHALL have port busy  output  1  high while a delay is loaded and not yet expired.
REQ-010 The block SHALL have port remaining  output  11  ticks left, unsigned.
REQ-011 The block SHALL have port timerState  output  2  debug encoding: 0=IDLE, 1=RUN, 2=PAUSED, 3=DONE.

Function
REQ-012 The block SHALL implement the four states IDLE, RUN, PAUSED and DONE; slowClk=1 exactly when the state is DONE; busy=1 exactly when the state is RUN or PAUSED.
REQ-013 The block SHALL hold an internal prescaler counting 0..TICK_DIV-1 and an 11-bit remaining register.
REQ-014 The block SHALL evaluate inputs at each edge in this fixed priority: cancel, then requestTime, then pauseTimer, then counting.
REQ-015 When cancel=1, the next state SHALL be IDLE, with prescaler=0 and remaining=0, and no slowClk pulse, regardless of the other inputs.
REQ-016 When requestTime=1 with slowClkRequest=N>0, the block SHALL load remaining=N and prescaler=0, and the next state SHALL be RUN (PAUSED if pauseTimer=1); this applies in every state, so a request in RUN or PAUSED is a retrigger and discards the old delay.
REQ-017 When requestTime=1 with slowClkRequest=0, the next state SHALL be DONE, giving slowClk high in the cycle following the capture edge, with remaining=0.
REQ-018 In RUN or PAUSED with pauseTimer=1 and no request or cancel, the next state SHALL be PAUSED, and prescaler and remaining SHALL hold.
REQ-019 In PAUSED with pauseTimer=0, the next state SHALL be RUN, and the count SHALL resume from the held prescaler value with no cycle lost or added beyond the paused cycles.
REQ-020 In RUN with pauseTimer=0, the prescaler SHALL increment; at TICK_DIV-1 it SHALL wrap to 0 and remaining SHALL decrement by 1.
REQ-021 When remaining goes from 1 to 0, the next state SHALL be DONE.
REQ-022 Latency SHALL be N*TICK_DIV cycles from the capture edge to the first cycle of slowClk=1, plus the number of paused cycles.
REQ-023 DONE SHALL last exactly one cycle; the next state SHALL be IDLE unless a request or cancel applies per REQ-014.
REQ-024 A request arriving in DONE SHALL not suppress the slowClk pulse of that cycle.
REQ-025 In IDLE without a request, the block SHALL hold prescaler=0 and remaining=0, and pauseTimer SHALL have no effect.
REQ-026 remaining SHALL never underflow; it SHALL be 0 in IDLE and in DONE.
REQ-027 requestTime held high for multiple cycles SHALL reload on every one of those cycles; expiry occurs only after the request drops.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-029 While resetN=0, the block SHALL hold state=IDLE, prescaler=0, remaining=0, slowClk=0, busy=0 and timerState=0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abort the delay; after release, the block SHALL remain in IDLE and SHALL produce no slowClk until a new request arrives.
REQ-031 The first edge after reset release SHALL already honour requestTime.

Verification
REQ-032 The bench SHALL cover: TICK_DIV=4, request N=3 at edge E0 -> busy=1 from E0; remaining 3,2,1 decrementing at E4, E8; slowClk=1 for exactly one cycle after E12; busy=0 and timerState=0 after E13.
REQ-033 The bench SHALL cover: TICK_DIV=4, N=2 with pauseTimer high for 5 cycles starting at E2 -> slowClk first high 13 cycles after the capture edge; remaining holds at 2 during the pause.
REQ-034 The bench SHALL cover: TICK_DIV=4, N=5 with retrigger N=1 at E6 -> the old delay is discarded and slowClk fires 4 cycles after E6, once only.
REQ-035 The bench SHALL cover: cancel at E7 of an N=3 run -> IDLE, remaining=0, and slowClk stays 0 for 50 further cycles.
REQ-036 The bench SHALL cover: request N=0 -> slowClk high in the next cycle, busy never high; request N=2047 with TICK_DIV=2 -> expiry after 4094 cycles.
REQ-037 The bench SHALL cover: resetN pulsed low mid-RUN -> all outputs 0 asynchronously and no pulse after release; request and cancel in the same cycle -> IDLE.
